// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises and oversamples the raw pins, decodes 11-bit
// frames, and queues good scan codes in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          iPS2_Clk,
    input  logic          iPS2_Data,
    output logic [7:0]    oData,
    output logic          oValid,
    input  logic          iReady,
    output logic [CW-1:0] oCount,
    output logic          oParity_Err,
    output logic          oFrame_Err,
    output logic          oOverflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    // Receiver handshake: the consumer takes oData on any rising edge with
    // oValid & iReady; oValid never drops without such a pop.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   perr_q, ferr_q, ovf_q;

    logic                   sync_clk, sync_data, fall;
    logic                   push, perr_evt, ferr_evt;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]          count_q, count_d;
    logic [7:0]             data_q, data_d;
    logic                   full, pop, push_ok, ovf_evt;

    assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
    assign sync_data = data_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~sync_clk;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], iPS2_Clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], iPS2_Data};
            clk_prev_q  <= sync_clk;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        tmo_d     = (state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
        push      = 1'b0;
        perr_evt  = 1'b0;
        ferr_evt  = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!sync_data) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d  = {sync_data, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_bad_d = ~(^{shift_q, sync_data});
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit outranks a parity error: one pulse per frame.
                    if (!sync_data)    ferr_evt = 1'b1;
                    else if (par_bad_q) perr_evt = 1'b1;
                    else               push     = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
            ferr_evt = 1'b1;
            state_d  = S_IDLE;
            shift_d  = '0;
            tmo_d    = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            tmo_q     <= tmo_d;
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = (count_q != '0) & iReady;
    assign push_ok = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;
    assign rd_next = rd_ptr_q + PW'(1);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
    end

    // Head register: refilled from storage on pop, or from the incoming byte
    // when that byte lands in an empty (or just-emptied) FIFO.
    always_comb begin
        data_d = data_q;
        if (pop) begin
            if (count_q > CW'(1)) data_d = mem[rd_next];
            else if (push_ok)     data_d = shift_q;
        end else if (count_q == '0 && push_ok) begin
            data_d = shift_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && push_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_next;
            count_q <= count_d;
            data_q  <= data_d;
            perr_q  <= perr_evt;
            ferr_q  <= ferr_evt;
            ovf_q   <= ovf_evt;
        end
    end

    assign oData       = data_q;
    assign oValid      = (count_q != '0);
    assign oCount      = count_q;
    assign oParity_Err = perr_q;
    assign oFrame_Err  = ferr_q;
    assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed/random frames for ps2_rx_fifo checked against a queue-based model of the
// receiver: frame outcome rules, FIFO occupancy, popped bytes and pulse counts.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 200;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       perr, ferr, ovf;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
        .Clock(clk), .Reset(rst_n), .iPS2_Clk(ps2_clk), .iPS2_Data(ps2_data),
        .oData(data), .oValid(valid), .iReady(ready), .oCount(count),
        .oParity_Err(perr), .oFrame_Err(ferr), .oOverflow(ovf)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int obs_perr = 0, obs_ferr = 0, obs_ovf = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int ferr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: occupancy against the model, then pulses, then pops.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("valid", 32'(valid), 32'(exp_q.size() != 0));
            if (perr) obs_perr++;
            if (ferr) begin obs_ferr++; ferr_cyc = cyc; end
            if (ovf) obs_ovf++;
            if (valid && ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'(data), 32'hFFFF_FFFF);
                else chk("pop_data", 32'(data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF/2) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF/2 - 1) @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1 ready = r;
    endtask

    // Sends a frame; the outcome is decided by the model at the stop-bit edge,
    // which the DUT sees SYNC+1 cycles after the pin falls.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b,
                              input logic pop_on_push);
        logic [9:0] bits;
        bits = {(~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge clk) ps2_data = stop_b;
        repeat (HALF/2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1 if (pop_on_push) ready = 1'b1;
        @(posedge clk);
        #1 if (pop_on_push) ready = 1'b0;
        if (!stop_b) exp_ferr++;
        else if (bad_par) exp_perr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf++;
        repeat (HALF - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF/2) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_perr"}, 32'(obs_perr), 32'(exp_perr));
        chk({tag, "_ferr"}, 32'(obs_ferr), 32'(exp_ferr));
        chk({tag, "_ovf"},  32'(obs_ovf),  32'(exp_ovf));
    endtask

    initial begin
        int delay;
        int waited;
        logic [7:0] rb;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_pulses", 32'({perr, ferr, ovf}), 32'h0);
        rst_n = 1'b1;

        // 1: good frame 0x1C with the consumer always ready
        set_ready(1'b1);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t1");
        chk("t1_drained", 32'(count), 32'h0);

        // 2: parity error then a good 0xF0
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t2a");
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t2b");

        // 3: stop bit 0 (with bad parity too: framing must win)
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t3");

        // 4: overflow with the consumer stalled, then drain
        set_ready(1'b0);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t4_full", 32'(count), 32'd4);
        check_pulses("t4a");
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        chk("t4_empty", 32'(valid), 32'h0);
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h15, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4_full_pop", 32'(count), 32'd4);
        check_pulses("t4b");
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        chk("t4_drain2", 32'(count), 32'h0);

        // 5: partial frame, clock stays high -> timeout
        ps2_bit(1'b0);
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        waited = 0;
        while (obs_ferr == exp_ferr && waited < 2 * TMO + 100) begin
            @(negedge clk);
            waited++;
        end
        exp_ferr++;
        delay = ferr_cyc - last_fall_cyc;
        chk("t5_tmo_seen", 32'(obs_ferr), 32'(exp_ferr));
        chk("t5_tmo_window", 32'(delay >= TMO - 5 && delay <= TMO + 15), 32'h1);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t5");

        // 6: reset mid-frame with two bytes queued
        set_ready(1'b0);
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(posedge clk); #1 rst_n = 1'b0; exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        chk("t6_count", 32'(count), 32'h0);
        chk("t6_valid", 32'(valid), 32'h0);
        repeat (5) @(negedge clk);
        check_pulses("t6a");
        set_ready(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_pulses("t6b");

        // Random traffic: random bytes, ~1/4 corrupted, random stalls
        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom_range(0, 255));
            set_ready(1'($urandom_range(0, 1)));
            send_frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), 1'b0);
        end
        set_ready(1'b1);
        repeat (20) @(negedge clk);
        check_pulses("rand");
        chk("rand_drained", 32'(count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
